bike_speed_odometer: RTL and testbench

- Cycle-computer core. Counts rising edges of a hall-effect wheel sensor.
- Reports wheel speed as edges per fixed measurement window.
- Reports accumulated distance as total edges since reset or clear.
- Sits between the sensor input pin and the display/telemetry logic. Runs on one system clock.

---
 rtl/bike_pkg.sv | 15 +
 rtl/hall_edge_sync.sv | 25 ++
 rtl/bike_speed_odometer.sv | 88 ++++++++
 tb/tb_bike_speed_odometer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// rtl/bike_pkg.sv - shared widths, types and saturating increment for the cycle computer
package bike_pkg;

  localparam int SPEED_W = 9;
  localparam int DIST_W  = 13;

  typedef logic [SPEED_W-1:0] speed_t;
  typedef logic [DIST_W-1:0]  dist_t;

  // Callers pass a zero-extended counter and its all-ones ceiling, then size-cast the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/hall_edge_sync.sv
// rtl/hall_edge_sync.sv - two-flop synchronizer plus rising-edge detect for the hall sensor
module hall_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic hall_in,
  output logic hall_edge
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= hall_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign hall_edge = s2 & ~s3;

endmodule

// File: rtl/bike_speed_odometer.sv
// rtl/bike_speed_odometer.sv - windowed wheel speed and saturating distance counter
// Optional peak-speed tracking is built when SPEED_PEAK_EN is defined.
module bike_speed_odometer #(
  parameter int WINDOW_CYCLES = 100,
  parameter int SPEED_W       = 9,
  parameter int DIST_W        = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hall_in,
  input  logic               clr_dist,
  output logic [SPEED_W-1:0] speed,
  output logic               speed_valid,
  output logic [DIST_W-1:0]  distance
`ifdef SPEED_PEAK_EN
  ,
  output logic [SPEED_W-1:0] peak_speed
`endif
);

  import bike_pkg::*;

  localparam int               CNT_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [31:0]      SPEED_MAX = (32'd1 << SPEED_W) - 32'd1;
  localparam logic [31:0]      DIST_MAX  = (32'd1 << DIST_W) - 32'd1;

  logic               hall_edge;
  logic [CNT_W-1:0]   win_cnt;
  logic [SPEED_W-1:0] acc;
  logic [SPEED_W-1:0] acc_inc;
  logic [SPEED_W-1:0] speed_next;
  logic               win_end;

  hall_edge_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .hall_in   (hall_in),
    .hall_edge (hall_edge)
  );

  assign win_end    = (win_cnt == WIN_LAST);
  assign acc_inc    = SPEED_W'(sat_inc(32'(acc), SPEED_MAX));
  // An edge landing on the last window cycle still belongs to the closing window.
  assign speed_next = hall_edge ? acc_inc : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt     <= '0;
      acc         <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= win_end;
      if (win_end) begin
        win_cnt <= '0;
        acc     <= '0;
        speed   <= speed_next;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        if (hall_edge) acc <= acc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      distance <= '0;
    end else if (clr_dist) begin
      distance <= '0;
    end else if (hall_edge) begin
      distance <= DIST_W'(sat_inc(32'(distance), DIST_MAX));
    end
  end

`ifdef SPEED_PEAK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_speed <= '0;
    end else if (clr_dist) begin
      peak_speed <= '0;
    end else if (win_end && (speed_next > peak_speed)) begin
      peak_speed <= speed_next;
    end
  end
`endif

endmodule

// File: tb/tb_bike_speed_odometer.sv
// tb/tb_bike_speed_odometer.sv - scoreboard bench for bike_speed_odometer (optionally with SPEED_PEAK_EN)
module tb_bike_speed_odometer;

  import bike_pkg::*;

  localparam int WIN     = 100;
  localparam int WIN_SAT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   reset, hall_in, clr_dist, speed_valid;
  speed_t speed;
  dist_t  distance;
  logic   reset_sat, hall_sat, clr_sat, valid_s;
  speed_t speed_s;
  dist_t  dist_s;
`ifdef SPEED_PEAK_EN
  speed_t peak_speed, peak_s;
  int     peak_q[$];
`endif

  int tests = 0;
  int fails = 0;
  int speed_q[$];
  int sat_q[$];

  bike_speed_odometer #(.WINDOW_CYCLES(WIN), .SPEED_W(SPEED_W), .DIST_W(DIST_W)) dut (
    .clk(clk), .reset(reset), .hall_in(hall_in), .clr_dist(clr_dist),
    .speed(speed), .speed_valid(speed_valid), .distance(distance)
`ifdef SPEED_PEAK_EN
    , .peak_speed(peak_speed)
`endif
  );

  bike_speed_odometer #(.WINDOW_CYCLES(WIN_SAT), .SPEED_W(SPEED_W), .DIST_W(DIST_W)) dut_sat (
    .clk(clk), .reset(reset_sat), .hall_in(hall_sat), .clr_dist(clr_sat),
    .speed(speed_s), .speed_valid(valid_s), .distance(dist_s)
`ifdef SPEED_PEAK_EN
    , .peak_speed(peak_s)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (speed_valid) begin
      if (speed_q.size() == 0) check("speed_valid_unexpected", 1, 0);
      else begin
        check("speed", int'(speed), speed_q.pop_front());
`ifdef SPEED_PEAK_EN
        check("peak_speed", int'(peak_speed), peak_q.pop_front());
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (valid_s) begin
      if (sat_q.size() == 0) check("sat_valid_unexpected", 1, 0);
      else check("sat_speed", int'(speed_s), sat_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; hall_in = 1'b0; clr_dist = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_window(input int period, input int hi, input int exp_speed);
    speed_q.push_back(exp_speed);
    for (int c = 0; c < WIN; c++) begin
      hall_in = ((c % period) < hi);
      @(negedge clk);
    end
    hall_in = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; hall_in = 1'b0; clr_dist = 1'b0;
    reset_sat = 1'b0; hall_sat = 1'b0; clr_sat = 1'b0;

    // Held in reset with a busy sensor: everything stays cleared.
    for (int c = 0; c < 20; c++) begin
      hall_in = c[0];
      @(negedge clk);
      if (c % 5 == 4) begin
        check("rst_speed", int'(speed), 0);
        check("rst_dist", int'(distance), 0);
        check("rst_valid", int'(speed_valid), 0);
      end
    end
    hall_in = 1'b0;
    reset = 1'b1;
    speed_q.push_back(0);
`ifdef SPEED_PEAK_EN
    peak_q.push_back(0);
`endif
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (speed_valid) break;
    end
    check("first_valid_cycle", n, WIN);
    @(negedge clk);
    check("valid_one_cycle", int'(speed_valid), 0);

    // Edge latency, clear, and clear against a coincident edge.
    do_reset();
    repeat (5) @(negedge clk);
    hall_in = 1'b1;
    @(negedge clk); check("lat_n", int'(distance), 0);
    @(negedge clk); check("lat_n1", int'(distance), 0);
    @(negedge clk); check("lat_n2", int'(distance), 1);
    hall_in = 1'b0;
    repeat (4) @(negedge clk);
    clr_dist = 1'b1;
    @(negedge clk);
    clr_dist = 1'b0;
    check("clr", int'(distance), 0);
    hall_in = 1'b1;
    repeat (3) @(negedge clk);
    check("dist_after_clr", int'(distance), 1);
    hall_in = 1'b0;
    repeat (4) @(negedge clk);
    hall_in = 1'b1;
    repeat (2) @(negedge clk);
    clr_dist = 1'b1;
    @(negedge clk);
    clr_dist = 1'b0;
    check("clr_vs_edge", int'(distance), 0);
    repeat (3) @(negedge clk);
    check("clr_hold", int'(distance), 0);
    hall_in = 1'b0;

    // Steady rates 10,10,20,5 then an idle sensor.
    do_reset();
`ifdef SPEED_PEAK_EN
    peak_q.push_back(10);
`endif
    run_window(10, 5, 10);  check("dist_w0", int'(distance), 10);
`ifdef SPEED_PEAK_EN
    peak_q.push_back(10);
`endif
    run_window(10, 5, 10);  check("dist_w1", int'(distance), 20);
`ifdef SPEED_PEAK_EN
    peak_q.push_back(20);
`endif
    run_window(5, 3, 20);   check("dist_w2", int'(distance), 40);
`ifdef SPEED_PEAK_EN
    peak_q.push_back(20);
`endif
    run_window(20, 10, 5);  check("dist_w3", int'(distance), 45);
`ifdef SPEED_PEAK_EN
    peak_q.push_back(20);
`endif
    run_window(1, 0, 0);    check("dist_idle", int'(distance), 45);
    repeat (10) @(negedge clk);
    clr_dist = 1'b1;
    @(negedge clk);
    clr_dist = 1'b0;
    check("clr_mid_window", int'(distance), 0);
`ifdef SPEED_PEAK_EN
    check("peak_clr", int'(peak_speed), 0);
`endif

    // Reset in the middle of a window with five edges pending.
    do_reset();
`ifdef SPEED_PEAK_EN
    peak_q.push_back(10);
`endif
    run_window(10, 5, 10);
    for (int c = 0; c < 50; c++) begin
      hall_in = ((c % 10) < 5);
      @(negedge clk);
    end
    hall_in = 1'b0;
    check("mid_dist_before", int'(distance), 15);
    check("mid_speed_before", int'(speed), 10);
    reset = 1'b0;
    #1;
    check("mid_rst_speed", int'(speed), 0);
    check("mid_rst_dist", int'(distance), 0);
    @(negedge clk);
    reset = 1'b1;
`ifdef SPEED_PEAK_EN
    peak_q.push_back(5);
`endif
    run_window(20, 10, 5);
    check("mid_dist_after", int'(distance), 5);
    @(negedge clk);
    reset = 1'b0;

    // Saturation on the long-window instance, sensor toggling every clock.
    reset_sat = 1'b1;
    for (int k = 0; k < 9; k++) sat_q.push_back(511);
    for (int c = 0; c < 9 * WIN_SAT; c++) begin
      hall_sat = ~c[0];
      @(negedge clk);
      if (c == 7999) check("sat_dist_mid", int'(dist_s), 3999);
    end
    check("sat_dist_stuck", int'(dist_s), 8191);
    for (int c = 0; c < 6; c++) begin
      hall_sat = c[0];
      @(negedge clk);
    end
    check("sat_dist_hold", int'(dist_s), 8191);

    check("speed_q_drained", speed_q.size(), 0);
    check("sat_q_drained", sat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
